// File: rtl/mem_ctrl_pkg.sv
// Shared types for the memory access controller: FSM states, access size
// encodings, response exception codes and the byte-lane helper functions.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } mem_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    localparam logic [1:0] EXC_NONE      = 2'b00;
    localparam logic [1:0] EXC_LOAD_MIS  = 2'b01;
    localparam logic [1:0] EXC_STORE_MIS = 2'b10;
    localparam logic [1:0] EXC_BUS_TO    = 2'b11;

    // The illegal size is folded into the misaligned case so it never reaches memory.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return off[0];
            SIZE_WORD: return (off != 2'b00);
            default:   return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SIZE_BYTE: return 4'b0001 << off;
            SIZE_HALF: return off[1] ? 4'b1100 : 4'b0011;
            SIZE_WORD: return 4'b1111;
            default:   return 4'b0000;
        endcase
    endfunction

    // Store data is replicated across all lanes so mem_be alone selects the bytes.
    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SIZE_BYTE: return {4{wdata[7:0]}};
            SIZE_HALF: return {2{wdata[15:0]}};
            default:   return wdata;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Bundle of the MEM-stage request/response signals and the memory bus.
// Handshake: a request transfers in any cycle where req_valid and req_ready
// are both high; rsp_valid is a single-cycle pulse with no back-pressure;
// on the memory side mem_en stays high with stable address/data until a
// cycle in which mem_ack is high, which completes the access.
interface mem_access_ctrl_if;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_sign;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_exc;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    // Controller side.
    modport slave (
        input  req_valid, req_we, req_size, req_sign, req_addr, req_wdata,
        input  mem_rdata, mem_ack,
        output req_ready, stall, rsp_valid, rsp_rdata, rsp_exc,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );

    // Pipeline and memory side.
    modport master (
        output req_valid, req_we, req_size, req_sign, req_addr, req_wdata,
        output mem_rdata, mem_ack,
        input  req_ready, stall, rsp_valid, rsp_rdata, rsp_exc,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_access_ctrl_load_align.sv
// Moves the addressed byte/half of a read word down to bit 0 and extends it.
module load_align
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        sign,
    output logic [31:0] data
);

    logic [31:0] shifted;

    assign shifted = word >> {offset, 3'b000};

    // Sign or zero extension from the top bit of the accessed quantity.
    always_comb begin
        data = shifted;
        case (size)
            SIZE_BYTE: data = {{24{sign & shifted[7]}}, shifted[7:0]};
            SIZE_HALF: data = {{16{sign & shifted[15]}}, shifted[15:0]};
            default:   data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store unit front end: accepts one MEM-stage request at a time, runs
// it on the memory bus with a timeout, and returns aligned load data or an
// exception code in a one-cycle response.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset_n,
    mem_access_ctrl_if.slave bus,
    output mem_state_t state_dbg
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    mem_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic        sign_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [1:0]  exc_q;

    logic        req_mis;
    logic        accept;
    logic        reject;
    logic        done;
    logic        timeout;
    logic        in_idle;
    logic        in_access;
    logic        in_resp;
    logic [31:0] load_data;

    assign req_mis   = is_misaligned(bus.req_size, bus.req_addr[1:0]);
    assign in_idle   = (state_q == ST_IDLE);
    assign in_access = (state_q == ST_ACCESS);
    assign in_resp   = (state_q == ST_RESP);

    load_align u_load_align (
        .word   (bus.mem_rdata),
        .offset (addr_q[1:0]),
        .size   (size_q),
        .sign   (sign_q),
        .data   (load_data)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next state; an ack in the timeout cycle still completes normally.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        reject  = 1'b0;
        done    = 1'b0;
        timeout = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (req_mis) begin
                        reject  = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        accept  = 1'b1;
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                if (bus.mem_ack) begin
                    done    = 1'b1;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    timeout = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Request latch, access cycle counter and response registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= SIZE_BYTE;
            sign_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            exc_q   <= EXC_NONE;
        end else begin
            if (accept) begin
                cnt_q   <= '0;
                we_q    <= bus.req_we;
                size_q  <= bus.req_size;
                sign_q  <= bus.req_sign;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end else if (in_access && !done && !timeout) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (reject) begin
                rdata_q <= '0;
                exc_q   <= bus.req_we ? EXC_STORE_MIS : EXC_LOAD_MIS;
            end else if (done) begin
                rdata_q <= we_q ? 32'h0 : load_data;
                exc_q   <= EXC_NONE;
            end else if (timeout) begin
                rdata_q <= '0;
                exc_q   <= EXC_BUS_TO;
            end
        end
    end

    assign bus.req_ready = in_idle;
    assign bus.stall     = reset_n & (in_access | (in_idle & bus.req_valid & ~req_mis));
    assign bus.rsp_valid = in_resp;
    assign bus.rsp_rdata = in_resp ? rdata_q : 32'h0;
    assign bus.rsp_exc   = in_resp ? exc_q : EXC_NONE;
    assign bus.mem_en    = in_access;
    assign bus.mem_we    = in_access & we_q;
    assign bus.mem_be    = in_access ? byte_enables(size_q, addr_q[1:0]) : 4'b0000;
    assign bus.mem_addr  = in_access ? {addr_q[31:2], 2'b00} : 32'h0;
    assign bus.mem_wdata = in_access ? lane_data(size_q, wdata_q) : 32'h0;
    assign state_dbg     = state_q;

endmodule
